// File: rtl/change_dispenser_if.sv
// Handshake/status bundle between the sale logic, the change dispenser and the hopper.
// Stock outputs exist only when COIN_INVENTORY_EN is defined.
interface change_dispenser_if #(parameter int W = 32);
    logic         start;
    logic [W-1:0] change_in;
    logic         disp_ack;
    logic         disp_valid;
    logic [1:0]   disp_denom;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] remaining;
    logic [7:0]   cnt_hi;
    logic [7:0]   cnt_mid;
    logic [7:0]   cnt_lo;
`ifdef COIN_INVENTORY_EN
    logic [7:0]   stock_hi;
    logic [7:0]   stock_mid;
    logic [7:0]   stock_lo;
`endif

    modport slave (
        input  start, change_in, disp_ack,
        output disp_valid, disp_denom, busy, done, err, remaining, cnt_hi, cnt_mid, cnt_lo
`ifdef COIN_INVENTORY_EN
        , output stock_hi, stock_mid, stock_lo
`endif
    );

    modport master (
        output start, change_in, disp_ack,
        input  disp_valid, disp_denom, busy, done, err, remaining, cnt_hi, cnt_mid, cnt_lo
`ifdef COIN_INVENTORY_EN
        , input stock_hi, stock_mid, stock_lo
`endif
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: one piece per hopper handshake, largest denomination first.
// Optional COIN_INVENTORY_EN adds per-denomination stock tracking.
module change_dispenser #(
    parameter int W           = 32,
    parameter int DENOM_HI    = 10,
    parameter int DENOM_MID   = 5,
    parameter int DENOM_LO    = 1,
    parameter int MAX_CHANGE  = 100,
    parameter int ACK_TIMEOUT = 1000
`ifdef COIN_INVENTORY_EN
    , parameter int STOCK_HI  = 20,
    parameter int STOCK_MID   = 20,
    parameter int STOCK_LO    = 50
`endif
) (
    input logic          clk,
    input logic          rst,
    change_dispenser_if.slave bus
);
    localparam logic [W-1:0] D_HI  = W'(DENOM_HI);
    localparam logic [W-1:0] D_MID = W'(DENOM_MID);
    localparam logic [W-1:0] D_LO  = W'(DENOM_LO);
    localparam logic [W-1:0] D_MAX = W'(MAX_CHANGE);
    localparam int           TW    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PICK, ISSUE, DONE, ERR} state_t;
    state_t state, state_nx;

    logic [W-1:0]  remaining;
    logic [7:0]    cnt_hi, cnt_mid, cnt_lo;
    logic [1:0]    denom_q, pick_code;
    logic [W-1:0]  denom_val;
    logic [TW-1:0] wait_cnt;
    logic          hi_ok, mid_ok, lo_ok;
    logic          accept, timeout;

`ifdef COIN_INVENTORY_EN
    logic [7:0] stock_hi, stock_mid, stock_lo;
    assign hi_ok  = (stock_hi  != 8'd0);
    assign mid_ok = (stock_mid != 8'd0);
    assign lo_ok  = (stock_lo  != 8'd0);
    assign bus.stock_hi  = stock_hi;
    assign bus.stock_mid = stock_mid;
    assign bus.stock_lo  = stock_lo;
`else
    assign hi_ok  = 1'b1;
    assign mid_ok = 1'b1;
    assign lo_ok  = 1'b1;
`endif

    assign accept  = bus.start && (state == IDLE || state == DONE || state == ERR);
    assign timeout = (wait_cnt == TW'(ACK_TIMEOUT - 1));

    // pick_code of 00 with remaining>0 means nothing usable is left in stock
    always_comb begin
        pick_code = 2'b00;
        if (remaining >= D_HI && hi_ok)        pick_code = 2'b11;
        else if (remaining >= D_MID && mid_ok) pick_code = 2'b10;
        else if (remaining >= D_LO && lo_ok)   pick_code = 2'b01;
    end

    always_comb begin
        denom_val = '0;
        case (denom_q)
            2'b11:   denom_val = D_HI;
            2'b10:   denom_val = D_MID;
            2'b01:   denom_val = D_LO;
            default: denom_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (state == DONE) state_nx = IDLE;
                if (accept)        state_nx = (bus.change_in > D_MAX) ? ERR : PICK;
            end
            PICK: begin
                if (remaining == '0)         state_nx = DONE;
                else if (pick_code == 2'b00) state_nx = ERR;
                else                         state_nx = ISSUE;
            end
            ISSUE: begin
                if (bus.disp_ack)  state_nx = PICK;
                else if (timeout)  state_nx = ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            cnt_hi    <= '0;
            cnt_mid   <= '0;
            cnt_lo    <= '0;
            denom_q   <= '0;
            wait_cnt  <= '0;
`ifdef COIN_INVENTORY_EN
            stock_hi  <= 8'(STOCK_HI);
            stock_mid <= 8'(STOCK_MID);
            stock_lo  <= 8'(STOCK_LO);
`endif
        end else begin
            if (accept) begin
                remaining <= bus.change_in;
                cnt_hi    <= '0;
                cnt_mid   <= '0;
                cnt_lo    <= '0;
            end
            if (state == PICK) begin
                denom_q  <= pick_code;
                wait_cnt <= '0;
            end
            if (state == ISSUE) begin
                if (bus.disp_ack) begin
                    remaining <= remaining - denom_val;
                    case (denom_q)
                        2'b11: begin
                            if (cnt_hi != 8'hFF) cnt_hi <= cnt_hi + 8'd1;
`ifdef COIN_INVENTORY_EN
                            stock_hi <= stock_hi - 8'd1;
`endif
                        end
                        2'b10: begin
                            if (cnt_mid != 8'hFF) cnt_mid <= cnt_mid + 8'd1;
`ifdef COIN_INVENTORY_EN
                            stock_mid <= stock_mid - 8'd1;
`endif
                        end
                        2'b01: begin
                            if (cnt_lo != 8'hFF) cnt_lo <= cnt_lo + 8'd1;
`ifdef COIN_INVENTORY_EN
                            stock_lo <= stock_lo - 8'd1;
`endif
                        end
                        default: ;
                    endcase
                end else begin
                    wait_cnt <= wait_cnt + TW'(1);
                end
            end
        end
    end

    assign bus.disp_valid = (state == ISSUE);
    assign bus.disp_denom = (state == ISSUE) ? denom_q : 2'b00;
    assign bus.busy       = (state == PICK) || (state == ISSUE);
    assign bus.done       = (state == DONE);
    assign bus.err        = (state == ERR);
    assign bus.remaining  = remaining;
    assign bus.cnt_hi     = cnt_hi;
    assign bus.cnt_mid    = cnt_mid;
    assign bus.cnt_lo     = cnt_lo;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: expected denominations are queued at start and
// popped as the hopper handshake is served.
module tb_change_dispenser;
    localparam int W  = 32;
    localparam int TO = 1000;
    localparam logic [1:0] HI = 2'b11, MID = 2'b10, LO = 2'b01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [1:0] exp_q[$];

    change_dispenser_if #(.W(W)) bus ();
    change_dispenser #(.W(W), .ACK_TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef COIN_INVENTORY_EN
    change_dispenser_if #(.W(W)) bus2 ();
    change_dispenser #(.W(W), .ACK_TIMEOUT(TO), .STOCK_HI(0), .STOCK_LO(0))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pay(input logic [31:0] v);
        bus.start = 1'b1;
        bus.change_in = v;
        tick();
        bus.start = 1'b0;
        bus.change_in = 32'hDEAD_BEEF;
    endtask

    // wait for a request, compare it with the queue head, ack one cycle later
    task automatic serve_one();
        int n = 0;
        logic [1:0] e;
        while (!bus.disp_valid && n < 20) begin tick(); n++; end
        check("valid_wait", 32'(bus.disp_valid), 32'd1);
        if (!bus.disp_valid) return;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
        check("denom", 32'(bus.disp_denom), 32'(e));
        tick();
        bus.disp_ack = 1'b1;
        tick();
        bus.disp_ack = 1'b0;
        check("valid_drop", 32'(bus.disp_valid), 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 20) begin tick(); n++; end
        check("done", 32'(bus.done), 32'd1);
        tick();
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int vcnt;
        bus.start = 1'b0;
        bus.change_in = '0;
        bus.disp_ack = 1'b0;
`ifdef COIN_INVENTORY_EN
        bus2.start = 1'b0;
        bus2.change_in = '0;
        bus2.disp_ack = 1'b0;
`endif
        #12;
        check("rst_valid", 32'(bus.disp_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_rem", bus.remaining, 32'd0);
        rst = 1'b0;
        tick();

        // 1: 18 -> HI, MID, LO x3
        exp_q.push_back(HI); exp_q.push_back(MID);
        exp_q.push_back(LO); exp_q.push_back(LO); exp_q.push_back(LO);
        start_pay(32'd18);
        check("t1_busy", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 5; i++) serve_one();
        wait_done();
        check("t1_rem", bus.remaining, 32'd0);
        check("t1_hi", 32'(bus.cnt_hi), 32'd1);
        check("t1_mid", 32'(bus.cnt_mid), 32'd1);
        check("t1_lo", 32'(bus.cnt_lo), 32'd3);

        // 2: zero change, stray ack held high must be ignored
        bus.disp_ack = 1'b1;
        start_pay(32'd0);
        check("t2_done_early", 32'(bus.done), 32'd0);
        tick();
        check("t2_done", 32'(bus.done), 32'd1);
        check("t2_valid", 32'(bus.disp_valid), 32'd0);
        tick();
        check("t2_done_pulse", 32'(bus.done), 32'd0);
        check("t2_hi", 32'(bus.cnt_hi), 32'd0);
        check("t2_lo", 32'(bus.cnt_lo), 32'd0);
        bus.disp_ack = 1'b0;

        // 3: underpaid sale wraps negative -> err, then a good payout clears it
        start_pay(32'hFFFF_FFF6);
        check("t3_err", 32'(bus.err), 32'd1);
        check("t3_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("t3_novalid", 32'(bus.disp_valid), 32'd0);
            tick();
        end
        check("t3_err_held", 32'(bus.err), 32'd1);
        exp_q.push_back(MID); exp_q.push_back(LO); exp_q.push_back(LO);
        start_pay(32'd7);
        check("t3_err_clr", 32'(bus.err), 32'd0);
        for (int i = 0; i < 3; i++) serve_one();
        wait_done();
        check("t3_mid", 32'(bus.cnt_mid), 32'd1);
        check("t3_lo", 32'(bus.cnt_lo), 32'd2);

        // 5: reset during the second request aborts at once
        exp_q.push_back(HI); exp_q.push_back(MID);
        start_pay(32'd15);
        serve_one();
        vcnt = 0;
        while (!bus.disp_valid && vcnt < 20) begin tick(); vcnt++; end
        check("t5_denom", 32'(bus.disp_denom), 32'(exp_q.pop_front()));
        #2 rst = 1'b1;
        #1;
        check("t5_valid", 32'(bus.disp_valid), 32'd0);
        check("t5_denom0", 32'(bus.disp_denom), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_rem", bus.remaining, 32'd0);
        check("t5_hi", 32'(bus.cnt_hi), 32'd0);
        check("t5_mid", 32'(bus.cnt_mid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        exp_q.push_back(MID); exp_q.push_back(LO);
        start_pay(32'd6);
        for (int i = 0; i < 2; i++) serve_one();
        wait_done();
        check("t5_cmid", 32'(bus.cnt_mid), 32'd1);
        check("t5_clo", 32'(bus.cnt_lo), 32'd1);

        // 4: ack withheld -> request held for exactly TO cycles, then err with state frozen
        start_pay(32'd10);
        vcnt = 0;
        for (int i = 0; i < TO + 50; i++) begin
            if (bus.err) break;
            if (bus.disp_valid) vcnt++;
            tick();
        end
        check("t4_cycles", 32'(vcnt), 32'(TO));
        check("t4_err", 32'(bus.err), 32'd1);
        check("t4_valid", 32'(bus.disp_valid), 32'd0);
        check("t4_rem", bus.remaining, 32'd10);
        check("t4_hi", 32'(bus.cnt_hi), 32'd0);
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);

`ifdef COIN_INVENTORY_EN
        // 6: no HI/LO stock -> 20 pays as MID x4, then 3 is unpayable
        bus2.start = 1'b1; bus2.change_in = 32'd20;
        tick();
        bus2.start = 1'b0;
        for (int p = 0; p < 4; p++) begin
            vcnt = 0;
            while (!bus2.disp_valid && vcnt < 20) begin tick(); vcnt++; end
            check("t6_denom", 32'(bus2.disp_denom), 32'(MID));
            tick();
            bus2.disp_ack = 1'b1;
            tick();
            bus2.disp_ack = 1'b0;
        end
        vcnt = 0;
        while (!bus2.done && vcnt < 20) begin tick(); vcnt++; end
        check("t6_done", 32'(bus2.done), 32'd1);
        check("t6_stock_mid", 32'(bus2.stock_mid), 32'd16);
        check("t6_cnt_mid", 32'(bus2.cnt_mid), 32'd4);
        tick();
        bus2.start = 1'b1; bus2.change_in = 32'd3;
        tick();
        bus2.start = 1'b0;
        tick();
        check("t6_err", 32'(bus2.err), 32'd1);
        check("t6_rem", bus2.remaining, 32'd3);
        check("t6_valid", 32'(bus2.disp_valid), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
